probe_sequencer: RTL and testbench

Parametrised moisture-probe arm sequencer. Lowers the probe servo, dwells a programmable number of PWM periods while taking repeated sensor reads, and retries on inconsistent reads. Raises the probe, then drives the marker servo selected by the stable reading through its own lower/raise cycle. Sits between the rover control FSM (Enable/Done) and the servo PWM mux (ServoNum/ActiveServoDuty/ActivePeriodFinished).

---
 rtl/probe_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_probe_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/probe_sequencer.sv
// probe_sequencer: lowers the probe arm, dwells taking repeated reads, retries on unstable reads, then cycles the selected marker servo.
module probe_sequencer #(
  parameter int NUM_SERVOS = 4,
  parameter int SENSOR_W   = 2,
  parameter int DUTY_W     = 21,
  parameter int LOWER_DUTY = 60_000,
  parameter int RAISE_DUTY = 240_000,
  parameter int CNT_W      = 11,
  parameter int NUM_READS  = 3,
  parameter int MAX_RETRY  = 2
) (
  input  logic                          clk,
  input  logic                          ResetN,
  input  logic                          Enable,
  input  logic                          ActivePeriodFinished,
  input  logic [SENSOR_W-1:0]           SensorValue,
  input  logic [CNT_W-1:0]              DwellPeriods,
  input  logic [CNT_W-1:0]              SettlePeriods,
  output logic [$clog2(NUM_SERVOS)-1:0] ServoNum,
  output logic [DUTY_W-1:0]             ActiveServoDuty,
  output logic                          SampleValid,
  output logic [SENSOR_W-1:0]           SampleValue,
  output logic                          ModuleDone,
  output logic                          Fault
);
  localparam int SW = $clog2(NUM_SERVOS);
  localparam int RW = $clog2(MAX_RETRY + 1) + 1;
  typedef enum logic [3:0] {
    IDLE, PROBE_DOWN, PROBE_DWELL, PROBE_UP, PROBE_SETTLE,
    MARK_DOWN, MARK_DWELL, MARK_UP, MARK_SETTLE, DONE
  } state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_step;
  logic [RW-1:0] retry, retry_n;
  logic rpend, rpend_n, have, have_n, mis, mis_n, mis_now;
  logic [SENSOR_W-1:0] first, first_n, rd, sval_n;
  logic [SW-1:0] serv_n;
  logic [DUTY_W-1:0] duty_n;
  logic sv_n, done_n, fault_n, fin, cap, no_mark;
  logic [CNT_W:0] nd, ns, nper;
  logic [SENSOR_W:0] mark;
  assign nd = (DwellPeriods == '0) ? (CNT_W+1)'(1) : {1'b0, DwellPeriods};
  assign ns = (SettlePeriods == '0) ? (CNT_W+1)'(1) : {1'b0, SettlePeriods};
  assign nper = (state == PROBE_SETTLE || state == MARK_SETTLE) ? ns : nd;
  assign fin = ActivePeriodFinished && ({1'b0, cnt} + (CNT_W+1)'(1) >= nper);
  assign cap = ({1'b0, cnt} + (CNT_W+1)'(NUM_READS) >= nper);
  assign cnt_step = ActivePeriodFinished ? (fin ? '0 : cnt + 1'b1) : cnt;
  // The read buffer is the first captured value plus a sticky mismatch flag.
  assign rd = have ? first : SensorValue;
  assign mis_now = mis || (have && SensorValue != first);
  assign mark = {1'b0, SampleValue} + (SENSOR_W+1)'(1);
  assign no_mark = int'(mark) > NUM_SERVOS - 1;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    retry_n = retry;
    rpend_n = rpend;
    have_n = have;
    mis_n = mis;
    first_n = first;
    sval_n = SampleValue;
    serv_n = ServoNum;
    duty_n = ActiveServoDuty;
    sv_n = 1'b0;
    done_n = ModuleDone;
    fault_n = Fault;
    if (state == IDLE) begin
      if (Enable) begin
        state_n = PROBE_DOWN;
        cnt_n = '0;
        retry_n = '0;
        rpend_n = 1'b0;
        have_n = 1'b0;
        mis_n = 1'b0;
        fault_n = 1'b0;
      end
    end else if (state == DONE) begin
      serv_n = '0;
      if (!Enable) begin
        state_n = IDLE;
        done_n = 1'b0;
      end
    end else if (Enable) begin
      case (state)
        PROBE_DOWN: begin
          serv_n = '0;
          duty_n = DUTY_W'(LOWER_DUTY);
          rpend_n = 1'b0;
          state_n = PROBE_DWELL;
        end
        PROBE_DWELL: begin
          cnt_n = cnt_step;
          if (ActivePeriodFinished && cap) begin
            have_n = 1'b1;
            first_n = rd;
            mis_n = mis_now;
          end
          if (fin) begin
            have_n = 1'b0;
            mis_n = 1'b0;
            state_n = PROBE_UP;
            if (!mis_now) begin
              sval_n = rd;
              sv_n = 1'b1;
            end else if (int'(retry) < MAX_RETRY) begin
              retry_n = retry + 1'b1;
              rpend_n = 1'b1;
            end else fault_n = 1'b1;
          end
        end
        PROBE_UP: begin
          serv_n = '0;
          duty_n = DUTY_W'(RAISE_DUTY);
          state_n = PROBE_SETTLE;
        end
        PROBE_SETTLE: begin
          cnt_n = cnt_step;
          if (fin) begin
            if (rpend) state_n = PROBE_DOWN;
            else if (Fault || no_mark) begin
              state_n = DONE;
              done_n = 1'b1;
              serv_n = '0;
            end else state_n = MARK_DOWN;
          end
        end
        MARK_DOWN: begin
          serv_n = SW'(mark);
          duty_n = DUTY_W'(LOWER_DUTY);
          state_n = MARK_DWELL;
        end
        MARK_DWELL: begin
          cnt_n = cnt_step;
          state_n = fin ? MARK_UP : MARK_DWELL;
        end
        MARK_UP: begin
          serv_n = SW'(mark);
          duty_n = DUTY_W'(RAISE_DUTY);
          state_n = MARK_SETTLE;
        end
        MARK_SETTLE: begin
          cnt_n = cnt_step;
          if (fin) begin
            state_n = DONE;
            done_n = 1'b1;
            serv_n = '0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!ResetN) begin
      state <= IDLE;
      cnt <= '0;
      retry <= '0;
      rpend <= 1'b0;
      have <= 1'b0;
      mis <= 1'b0;
      first <= '0;
      SampleValue <= '0;
      ServoNum <= '0;
      ActiveServoDuty <= '0;
      SampleValid <= 1'b0;
      ModuleDone <= 1'b0;
      Fault <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      retry <= retry_n;
      rpend <= rpend_n;
      have <= have_n;
      mis <= mis_n;
      first <= first_n;
      SampleValue <= sval_n;
      ServoNum <= serv_n;
      ActiveServoDuty <= duty_n;
      SampleValid <= sv_n;
      ModuleDone <= done_n;
      Fault <= fault_n;
    end
  end
endmodule

// File: tb/tb_probe_sequencer.sv
// tb_probe_sequencer: table-driven full-run scenarios plus hand sequences for enable timing, freeze and reset.
module tb_probe_sequencer;
  localparam int LOWER = 60_000;
  localparam int RAISE = 240_000;
  logic clk = 1'b0;
  logic ResetN = 1'b0;
  logic Enable = 1'b0;
  logic apf = 1'b0;
  logic [1:0] sensor = '0;
  logic [10:0] dwell = 11'd5;
  logic [10:0] settle = 11'd2;
  logic [1:0] ServoNum;
  logic [20:0] duty;
  logic SampleValid, ModuleDone, Fault;
  logic [1:0] SampleValue;
  int checks = 0;
  int failures = 0;
  int probe_downs, marker_downs, marker_id, probe_pulses, marker_pulses, sv_count;
  logic prev_low;
  logic [1:0] prev_serv;

  probe_sequencer dut (
    .clk(clk), .ResetN(ResetN), .Enable(Enable), .ActivePeriodFinished(apf),
    .SensorValue(sensor), .DwellPeriods(dwell), .SettlePeriods(settle),
    .ServoNum(ServoNum), .ActiveServoDuty(duty), .SampleValid(SampleValid),
    .SampleValue(SampleValue), .ModuleDone(ModuleDone), .Fault(Fault)
  );

  always #5 clk = ~clk;

  // Observes outputs just after each edge alongside the pulse that edge consumed.
  always @(posedge clk) begin
    #1;
    if (!ResetN) begin
      probe_downs = 0; marker_downs = 0; marker_id = 0;
      probe_pulses = 0; marker_pulses = 0; sv_count = 0;
      prev_low = 1'b0; prev_serv = '0;
    end else begin
      if (duty == LOWER && !(prev_low && prev_serv == ServoNum)) begin
        if (ServoNum == 0) probe_downs++;
        else marker_downs++;
      end
      if (ServoNum != 0) marker_id = int'(ServoNum);
      if (apf && duty == LOWER && !ModuleDone) begin
        if (ServoNum == 0) probe_pulses++;
        else marker_pulses++;
      end
      if (SampleValid) sv_count++;
      prev_low = (duty == LOWER);
      prev_serv = ServoNum;
    end
  end

  typedef struct {
    int dwell, settle, mode, val;
    int sv, sval, fault, probes, marker, ppulses, mpulses;
  } scen_t;
  scen_t tbl[5];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    ResetN = 1'b0; Enable = 1'b0; apf = 1'b0;
    repeat (2) @(negedge clk);
    ResetN = 1'b1;
  endtask

  task automatic pulse();
    @(negedge clk);
    apf = 1'b1;
    @(negedge clk);
    apf = 1'b0;
    @(negedge clk);
  endtask

  // mode 0: constant; mode 1: toggle during the first probe cycle, then constant; mode 2: toggle always
  task automatic run_scen(input int idx);
    scen_t s;
    int n, ph;
    s = tbl[idx];
    do_reset();
    dwell = 11'(s.dwell); settle = 11'(s.settle); sensor = 2'(s.val);
    Enable = 1'b1;
    n = 0; ph = 0;
    while (!ModuleDone && n < 3000) begin
      @(negedge clk);
      n++;
      if (apf) begin
        apf = 1'b0;
        if (s.mode == 2 || (s.mode == 1 && probe_downs <= 1)) sensor = ~sensor;
        else if (s.mode == 1) sensor = 2'(s.val);
      end else begin
        ph++;
        if (ph == 3) begin apf = 1'b1; ph = 0; end
      end
    end
    apf = 1'b0;
    chk($sformatf("s%0d_timeout", idx), int'(n < 3000), 1);
    chk($sformatf("s%0d_fault", idx), int'(Fault), s.fault);
    chk($sformatf("s%0d_sval", idx), int'(SampleValue), s.sval);
    chk($sformatf("s%0d_svcount", idx), sv_count, s.sv);
    chk($sformatf("s%0d_probes", idx), probe_downs, s.probes);
    chk($sformatf("s%0d_marker", idx), marker_id, s.marker);
    chk($sformatf("s%0d_mdowns", idx), marker_downs, s.marker != 0 ? 1 : 0);
    chk($sformatf("s%0d_ppulses", idx), probe_pulses, s.ppulses);
    chk($sformatf("s%0d_mpulses", idx), marker_pulses, s.mpulses);
    chk($sformatf("s%0d_done_servo", idx), int'(ServoNum), 0);
    chk($sformatf("s%0d_done_duty", idx), int'(duty), RAISE);
    Enable = 1'b0;
    @(negedge clk);
    chk($sformatf("s%0d_done_clr", idx), int'(ModuleDone), 0);
    chk($sformatf("s%0d_fault_hold", idx), int'(Fault), s.fault);
  endtask

  initial begin
    int n;
    //        dwell settle mode val  sv sval fault probes marker ppulses mpulses
    tbl[0] = '{5, 2, 0, 1,  1, 1, 0, 1, 2, 5, 5};
    tbl[1] = '{5, 2, 1, 0,  1, 0, 0, 2, 1, 10, 5};
    tbl[2] = '{4, 1, 2, 0,  0, 0, 1, 3, 0, 12, 0};
    tbl[3] = '{3, 3, 0, 3,  1, 3, 0, 1, 0, 3, 0};
    tbl[4] = '{0, 0, 0, 2,  1, 2, 0, 1, 3, 1, 1};

    do_reset();
    @(negedge clk);
    chk("rst_servo", int'(ServoNum), 0);
    chk("rst_duty", int'(duty), 0);
    chk("rst_sv", int'(SampleValid), 0);
    chk("rst_sval", int'(SampleValue), 0);
    chk("rst_done", int'(ModuleDone), 0);
    chk("rst_fault", int'(Fault), 0);

    for (int i = 0; i < 5; i++) run_scen(i);

    // Enable latency and freeze mid-dwell
    do_reset();
    dwell = 11'd5; settle = 11'd2; sensor = 2'd1;
    @(negedge clk);
    Enable = 1'b1;
    @(negedge clk);
    chk("en_k1_duty", int'(duty), 0);
    @(negedge clk);
    chk("en_k2_duty", int'(duty), LOWER);
    pulse();
    pulse();
    Enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      apf = (i % 3 == 1);
      @(negedge clk);
    end
    apf = 1'b0;
    chk("frz_duty", int'(duty), LOWER);
    chk("frz_sv", sv_count, 0);
    Enable = 1'b1;
    pulse();
    pulse();
    chk("frz_4pulses_sv", sv_count, 0);
    chk("frz_4pulses_duty", int'(duty), LOWER);
    pulse();
    chk("frz_5pulses_sv", sv_count, 1);
    chk("frz_sval", int'(SampleValue), 1);

    // Reset during marker dwell
    n = 0;
    while (marker_downs == 0 && n < 400) begin
      pulse();
      n++;
    end
    chk("mk_reached", int'(n < 400), 1);
    chk("mk_servo", int'(ServoNum), 2);
    pulse();
    @(negedge clk);
    ResetN = 1'b0;
    @(negedge clk);
    chk("mrst_servo", int'(ServoNum), 0);
    chk("mrst_duty", int'(duty), 0);
    chk("mrst_sval", int'(SampleValue), 0);
    chk("mrst_done", int'(ModuleDone), 0);
    chk("mrst_fault", int'(Fault), 0);
    ResetN = 1'b1;
    repeat (3) @(negedge clk);
    chk("mrst_restart_duty", int'(duty), LOWER);
    chk("mrst_restart_servo", int'(ServoNum), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
